fir_shift_add_pipe: RTL and testbench
=====================================

FIR_SHIFT_ADD_PIPE -- requirements
Module: fir_shift_add_pipe

Interface
- REQ-001 SHALL have parameter DATA_W, default 16: sample and output width, unsigned.
- REQ-002 SHALL have parameter TAPS, default 5, legal range 2..16: number of delay-line taps.
- REQ-003 SHALL have parameter SHIFT_W, default 5: width of each per-tap right-shift amount.
- REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-006 SHALL have port clr, input, 1 bit: synchronous flush of the datapath only.
- REQ-007 SHALL have port in_valid, input, 1 bit: x carries a sample this cycle.
- REQ-008 SHALL have port x, input, DATA_W bits: input sample.
- REQ-009 SHALL have port coef_we, input, 1 bit: tap-configuration write strobe.
- REQ-010 SHALL have port coef_addr, input, 4 bits: tap index to write.
- REQ-011 SHALL have port coef_shift, input, SHIFT_W bits: new shift amount.
- REQ-012 SHALL have port coef_tap_en, input, 1 bit: new tap-enable bit.
- REQ-013 SHALL have port out_valid, output, 1 bit: dataout holds a new result.
- REQ-014 SHALL have port dataout, output, DATA_W bits: filter result.
- REQ-015 SHALL have port primed, output, 1 bit: delay line fully filled since last rst/clr.

Function
- REQ-016 SHALL, on an edge with in_valid=1, shift the delay line: d[0]<=x and d[k]<=d[k-1]; with in_valid=0 the delay line SHALL hold.
- REQ-017 SHALL compute sum = Σ over enabled taps of (d[k] >> shift[k]) at ACC_W = DATA_W + clog2(TAPS) bits, with no intermediate truncation.
- REQ-018 SHALL make a disabled tap contribute 0, and a tap with shift[k] >= DATA_W contribute 0.
- REQ-019 SHALL use two pipeline stages: a sample accepted in cycle N produces out_valid=1 and its dataout during cycle N+2.
- REQ-020 SHALL drive out_valid high for exactly one cycle per accepted sample, and hold dataout between results.
- REQ-021 SHALL use, for the stage-2 sum, the shift and enable values held during cycle N+1.
- REQ-022 SHALL, on an edge with coef_we=1 and coef_addr < TAPS, load shift[coef_addr] and en[coef_addr]; a coef_we with coef_addr >= TAPS SHALL be ignored.
- REQ-023 SHALL count accepted samples from 0, saturating at TAPS; primed = (count == TAPS).
- REQ-024 SHALL, on clr=1, zero the delay line, the count, the pipeline valid bits, out_valid and dataout, while retaining the shift and enable tables.
- REQ-025 SHALL give clr priority over a simultaneous in_valid; that sample is dropped.
- REQ-026 SHALL, when coef_we and in_valid coincide, perform both operations.

Reset
- REQ-027 SHALL, on rst=1, clear the delay line, count, pipeline, out_valid=0, dataout=0 and primed=0.
- REQ-028 SHALL, on rst=1, set shift[k] = TAPS-k and en[k] = 1 for every tap (defaults: 5,4,3,2,1).
- REQ-029 SHALL give rst priority over clr, coef_we and in_valid.
- REQ-030 SHALL, when rst is asserted mid-stream, emit no out_valid for in-flight samples.

Configuration
- REQ-031 SHALL support macro FIR_SAT_EN; when defined, dataout = min(sum, 2^DATA_W-1).
- REQ-032 SHALL, when FIR_SAT_EN is undefined, set dataout = sum mod 2^DATA_W (wrap).

Verification
- REQ-033 SHALL cover the impulse case: defaults, x=0x8000 then zeros -> dataout 0x0400, 0x0800, 0x1000, 0x2000, 0x4000, then 0x0000; each result 2 cycles after its input.
- REQ-034 SHALL cover overflow: coef write tap0 shift=0, five samples of 0xFFFF -> fifth result 0xEFFB (wrap) or 0xFFFF (FIR_SAT_EN).
- REQ-035 SHALL cover out-of-range configuration: tap2 shift=16 or en=0, impulse 0x8000 -> third result 0x0000; coef_addr=7 write -> no table change.
- REQ-036 SHALL cover clr: clr asserted with in_valid in cycle N -> no out_valid at N+2, primed=0, next impulse matches REQ-033.
- REQ-037 SHALL cover rst mid-stream: rst pulsed one cycle after a sample -> out_valid stays 0 and shifts return to 5,4,3,2,1.
- REQ-038 SHALL cover gapped input: in_valid toggling 1,0,0,1 -> delay line holds during gaps, exactly two out_valid pulses, primed set after the fifth accepted sample.

Source files
------------

// File: rtl/fir_shift_add_pipe.sv
// Shift-and-add FIR: sum of enabled taps d[k] >> shift[k]; FIR_SAT_EN selects saturating vs wrapping output.
// Latency: sample accepted in cycle N appears on dataout with a one-cycle out_valid pulse during cycle N+2.
// Backpressure: none; one sample per cycle may be accepted, with holes marked by in_valid=0.
module fir_shift_add_pipe #(
    parameter int DATA_W  = 16,
    parameter int TAPS    = 5,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  x,
    input  logic               coef_we,
    input  logic [3:0]         coef_addr,
    input  logic [SHIFT_W-1:0] coef_shift,
    input  logic               coef_tap_en,
    output logic               out_valid,
    output logic [DATA_W-1:0]  dataout,
    output logic               primed
);

    localparam int ACC_W = DATA_W + $clog2(TAPS);
    localparam int CNT_W = $clog2(TAPS + 1);

    logic [DATA_W-1:0]  d [TAPS];
    logic [SHIFT_W-1:0] shift_tab [TAPS];
    logic [TAPS-1:0]    en_tab;
    logic [CNT_W-1:0]   count;
    logic               s1_vld;
    logic [ACC_W-1:0]   sum;
    logic [DATA_W-1:0]  result;

    // Stage 1: delay line; a clr wins over a coincident sample, which is dropped.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < TAPS; k++) begin
                d[k] <= '0;
            end
            s1_vld <= 1'b0;
            count  <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                d[0] <= x;
                for (int k = 1; k < TAPS; k++) begin
                    d[k] <= d[k-1];
                end
                if (count != CNT_W'(TAPS)) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    // Tap tables survive clr; addresses at or beyond TAPS match no entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                shift_tab[k] <= SHIFT_W'(TAPS - k);
            end
            en_tab <= '1;
        end else if (coef_we) begin
            for (int k = 0; k < TAPS; k++) begin
                if (coef_addr == 4'(k)) begin
                    shift_tab[k] <= coef_shift;
                    en_tab[k]    <= coef_tap_en;
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (en_tab[k] && ({{(32-SHIFT_W){1'b0}}, shift_tab[k]} < 32'(DATA_W))) begin
                sum = sum + ACC_W'(d[k] >> shift_tab[k]);
            end
        end
    end

`ifdef FIR_SAT_EN
    always_comb begin
        result = DATA_W'(sum);
        if (sum > ACC_W'({DATA_W{1'b1}})) begin
            result = '1;
        end
    end
`else
    always_comb begin
        result = DATA_W'(sum);
    end
`endif

    // Stage 2: result register holds its value between valid results.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            out_valid <= 1'b0;
            dataout   <= '0;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                dataout <= result;
            end
        end
    end

    assign primed = (count == CNT_W'(TAPS));

endmodule

// File: tb/tb_fir_shift_add_pipe.sv
// Directed-vector bench for fir_shift_add_pipe at default parameters.
module tb_fir_shift_add_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [4:0]  coef_shift = '0;
    logic        coef_tap_en = 1'b0;
    logic        out_valid;
    logic [15:0] dataout;
    logic        primed;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_def  [6] = '{16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h0000};
    logic [15:0] exp_tap2 [6] = '{16'h0400, 16'h0800, 16'h0000, 16'h2000, 16'h4000, 16'h0000};

    fir_shift_add_pipe dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .x(x),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_shift(coef_shift),
        .coef_tap_en(coef_tap_en), .out_valid(out_valid), .dataout(dataout),
        .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic coef_write(input logic [3:0] a, input logic [4:0] s, input logic e);
        coef_we = 1'b1; coef_addr = a; coef_shift = s; coef_tap_en = e;
        cycle();
        coef_we = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
    endtask

    // Impulse of 0x8000 then five zeros; iteration i observes the result of input i-1.
    task automatic run_impulse(input string tag, input logic [15:0] exp_r [6]);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 6);
            x = (i == 0) ? 16'h8000 : 16'h0000;
            cycle();
            n_cmp++;
            if (out_valid !== (i >= 1 && i <= 6)) begin
                n_fail++;
                $display("FAIL %s out_valid step %0d: got %b want %b", tag, i, out_valid, (i >= 1 && i <= 6));
            end
            if (i >= 1 && i <= 6) begin
                n_cmp++;
                if (dataout !== exp_r[i-1]) begin
                    n_fail++;
                    $display("FAIL %s dataout result %0d: got %h want %h", tag, i - 1, dataout, exp_r[i-1]);
                end
            end
        end
        in_valid = 1'b0;
        x = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        n_cmp++;
        if ({out_valid, dataout, primed} !== 18'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%h p=%b want 0/0000/0", out_valid, dataout, primed);
        end
    endtask

    task automatic test_impulse();
        run_impulse("impulse_default", exp_def);
    endtask

    task automatic test_coef_range();
        coef_write(4'd2, 5'd16, 1'b1);
        run_impulse("tap2_shift16", exp_tap2);
        coef_write(4'd2, 5'd3, 1'b0);
        run_impulse("tap2_disabled", exp_tap2);
        coef_write(4'd2, 5'd3, 1'b1);
        coef_write(4'd7, 5'd0, 1'b0);
        run_impulse("addr7_ignored", exp_def);
    endtask

    // Tap0 shift=0 is written in the same cycle as the first 0xFFFF sample.
    task automatic test_overflow();
        logic [15:0] want5;
`ifdef FIR_SAT_EN
        want5 = 16'hFFFF;
`else
        want5 = 16'hEFFB;
`endif
        do_clr();
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 5);
            x = 16'hFFFF;
            coef_we = (i == 0); coef_addr = 4'd0; coef_shift = 5'd0; coef_tap_en = 1'b1;
            cycle();
            coef_we = 1'b0;
            if (i == 1) begin
                n_cmp++;
                if (out_valid !== 1'b1 || dataout !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL ovf_first: got v=%b d=%h want 1/ffff", out_valid, dataout);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || dataout !== want5) begin
                    n_fail++;
                    $display("FAIL ovf_fifth: got v=%b d=%h want 1/%h", out_valid, dataout, want5);
                end
            end
        end
        in_valid = 1'b0;
        coef_write(4'd0, 5'd5, 1'b1);
        do_clr();
    endtask

    task automatic test_clr();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; x = 16'h0000;
            cycle();
        end
        n_cmp++;
        if (primed !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_pre_primed: got %b want 1", primed);
        end
        x = 16'h1234;
        cycle();
        x = 16'h8000; clr = 1'b1;
        cycle();
        clr = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || dataout !== 16'h0000) begin
            n_fail++;
            $display("FAIL clr_inflight: got v=%b d=%h want 0/0000", out_valid, dataout);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || primed !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_dropped: got v=%b p=%b want 0/0", out_valid, primed);
        end
        cycle();
        run_impulse("after_clr", exp_def);
    endtask

    task automatic test_rst_midstream();
        coef_write(4'd1, 5'd9, 1'b1);
        in_valid = 1'b1; x = 16'h8000;
        cycle();
        in_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_inflight: got out_valid %b want 0", out_valid);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || dataout !== 16'h0000 || primed !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: got v=%b d=%h p=%b want 0/0000/0", out_valid, dataout, primed);
        end
        run_impulse("after_rst", exp_def);
    endtask

    // Gaps must freeze the delay line: the second sample sees the impulse in d[1].
    task automatic test_gapped();
        bit          v  [11] = '{1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0};
        logic [15:0] xs [11] = '{16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                                 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [15:0] ed [11] = '{16'h0400, 16'h0400, 16'h0400, 16'h0800, 16'h0800, 16'h0800,
                                 16'h1000, 16'h2000, 16'h4000, 16'h4000, 16'h4000};
        int accepted = 0;
        int pulses   = 0;
        do_clr();
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 11) ? v[i] : 1'b0;
            x = (i < 11) ? xs[i] : 16'h0;
            if (in_valid) accepted++;
            cycle();
            if (i >= 1) begin
                if (i <= 5 && out_valid === 1'b1) pulses++;
                n_cmp++;
                if (out_valid !== v[i-1] || dataout !== ed[i-1]) begin
                    n_fail++;
                    $display("FAIL gapped step %0d: got v=%b d=%h want %b/%h", i, out_valid, dataout, v[i-1], ed[i-1]);
                end
            end
            n_cmp++;
            if (primed !== (accepted >= 5)) begin
                n_fail++;
                $display("FAIL gapped_primed step %0d: got %b want %b", i, primed, (accepted >= 5));
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL gapped_pulses: got %0d want 2", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_coef_range();
        test_overflow();
        test_clr();
        test_rst_midstream();
        test_gapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
